// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/bubble sequencing for the 5-stage core
// Resolves load-use, taken branch, multi-cycle EX and data-memory stalls; counts stalls and flushes.
module hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    input  logic             dmem_stall,
    input  logic             count_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic [1:0]       state,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1
    } state_t;

    localparam int            TW         = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

    state_t        cur;
    state_t        nxt;
    logic [TW-1:0] mc_timer;
    logic [TW-1:0] timer_nxt;
    logic          mc_complete;
    logic          mc_complete_nxt;
    logic          set_complete;
    logic          set_timeout;
    logic          run_eval;
    logic          req_eff;
    logic          load_use;
    logic          mc_req;

    logic          pc_c;
    logic          ifw_c;
    logic          flush_c;
    logic          bubble_c;
    logic          hold_c;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // mc_complete marks that the op now in EX already finished, so its level
    // on ex_mc_start must not send us back into MC_WAIT.
    assign mc_req = ex_mc_start && !mc_complete;

    always_comb begin
        nxt          = cur;
        timer_nxt    = mc_timer;
        set_complete = 1'b0;
        set_timeout  = 1'b0;
        run_eval     = 1'b0;
        req_eff      = 1'b0;
        pc_c         = 1'b1;
        ifw_c        = 1'b1;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        hold_c       = 1'b0;

        case (cur)
            RUN: begin
                run_eval = 1'b1;
                req_eff  = mc_req;
            end
            MC_WAIT: begin
                if (mc_done) begin
                    run_eval     = 1'b1;
                    set_complete = 1'b1;
                    nxt          = RUN;
                end else begin
                    pc_c   = 1'b0;
                    ifw_c  = 1'b0;
                    hold_c = 1'b1;
                    if (mc_timer == TIMER_LAST) begin
                        set_timeout  = 1'b1;
                        set_complete = 1'b1;
                        nxt          = RUN;
                    end else begin
                        timer_nxt = mc_timer + 1'b1;
                    end
                end
            end
            default: nxt = RUN;
        endcase

        if (run_eval) begin
            if (dmem_stall) begin
                pc_c   = 1'b0;
                ifw_c  = 1'b0;
                hold_c = 1'b1;
            end else if (req_eff) begin
                pc_c      = 1'b0;
                ifw_c     = 1'b0;
                hold_c    = 1'b1;
                nxt       = MC_WAIT;
                timer_nxt = '0;
            end else if (ex_branch_taken) begin
                // A flushed ID instruction cannot be a load-use victim, so no stall.
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end else if (load_use) begin
                pc_c     = 1'b0;
                ifw_c    = 1'b0;
                bubble_c = 1'b1;
            end
        end
    end

    // Clear whenever EX advances; a same-cycle set only survives if EX is held.
    assign mc_complete_nxt = hold_c ? (mc_complete | set_complete) : 1'b0;

    assign pc_write     = !reset && pc_c;
    assign if_id_write  = !reset && ifw_c;
    assign if_id_flush  = !reset && flush_c;
    assign id_ex_bubble = !reset && bubble_c;
    assign ex_hold      = !reset && hold_c;
    assign state        = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= RUN;
            mc_timer    <= '0;
            mc_complete <= 1'b0;
            mc_timeout  <= 1'b0;
        end else begin
            cur         <= nxt;
            mc_timer    <= timer_nxt;
            mc_complete <= mc_complete_nxt;
            if (set_timeout) begin
                mc_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (count_clear) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write && !(&stall_count)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (if_id_flush && !(&flush_count)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
